rng_card_datapath: RTL

- Downstream datapath stage for the RNG control path; consumes its `state_o` (IDLE=0 / SEND=1) on `state_i`.
- A free-running 16-bit LFSR is sampled on each IDLE->SEND transition. The sample maps to an undealt card index 0..51 and is presented with a valid/ack handshake.
- A 52-bit dealt mask guarantees no repeats until a shuffle.

---
 rtl/rng_pkg.sv | 37 +++
 rtl/rng_lfsr16.sv | 34 +++
 rtl/rng_card_datapath.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rng_pkg
//  Description : Shared types and constants for the RNG card datapath:
//                FSM state encoding, control-path state values, deck
//                geometry and the 16-bit LFSR tap mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package rng_pkg;

  // Datapath FSM state encoding (2-bit, fixed values)
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_CHECK   = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  // Upstream control-path states as seen on state_i
  localparam logic CP_IDLE = 1'b0;
  localparam logic CP_SEND = 1'b1;

  // Deck geometry
  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fibonacci feedback bit: XOR of the tapped state bits
  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rng_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : rng_lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR. Shifts every cycle out
//                of reset. A zero seed would lock the register, so it is
//                replaced by 16'h0001.
//  Revision    : 1.0 - initial release
// ============================================================================
module rng_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] lfsr_o
);
  import rng_pkg::*;

  localparam logic [15:0] C_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_lfsr;

  // Shift left every cycle, feedback enters at bit 0
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lfsr <= C_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
    end
  end

  assign lfsr_o = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/rng_card_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : rng_card_datapath
//  Description : Card dealer behind the RNG control path. A rising edge on
//                state_i (IDLE->SEND) samples the LFSR, folds it into a deck
//                index, linear-probes the dealt mask for a free card and
//                presents it with a valid/ack handshake. No card repeats
//                until a shuffle.
//  Options     : RNG_AUTO_SHUFFLE_EN - a request against an empty deck
//                reshuffles and deals instead of raising empty_err_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module rng_card_datapath #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          DECK_SIZE = 52,
  parameter int          RANKS     = 13
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       state_i,
  input  logic       shuffle_i,
  input  logic       card_ack_i,
  output logic [5:0] card_o,
  output logic [1:0] suit_o,
  output logic [3:0] rank_o,
  output logic       card_valid_o,
  output logic       busy_o,
  output logic [5:0] cards_left_o,
  output logic       deck_empty_o,
  output logic       empty_err_o
);
  import rng_pkg::*;

  // Parameter legality: 6-bit index and a 4-suit deck
  if (DECK_SIZE > 64 || DECK_SIZE != 4 * RANKS || RANKS > 16) begin : g_param_err
    $error("rng_card_datapath: DECK_SIZE must be <= 64 and equal 4*RANKS");
  end

  localparam logic [5:0] C_DECK = 6'(DECK_SIZE);
  localparam logic [5:0] C_LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] C_R1   = 6'(RANKS);
  localparam logic [5:0] C_R2   = 6'(2 * RANKS);
  localparam logic [5:0] C_R3   = 6'(3 * RANKS);

  // --------------------------------------------------------------------------
  // Random source
  // --------------------------------------------------------------------------
  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;

  rng_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lfsr_o (w_lfsr)
  );

  // Only the low six bits feed the index fold
  assign w_lfsr_unused = ^w_lfsr[15:6];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic                   r_state_q;
  logic [DECK_SIZE-1:0]   r_mask;
  logic [5:0]             r_left;
  logic [5:0]             r_cand;
  logic [5:0]             r_card;
  logic [1:0]             r_suit;
  logic [3:0]             r_rank;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_err;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       w_req;
  logic [5:0] w_fold;
  logic [5:0] w_next_probe;
  logic       w_taken;
  logic [1:0] w_suit;
  logic [5:0] w_rem;
  logic [3:0] w_rank;

  // Draw request is the IDLE->SEND edge of the control path
  assign w_req = (state_i == CP_SEND) && (r_state_q == CP_IDLE);

  // Fold the 0..63 sample into 0..DECK_SIZE-1 (low indices slightly favoured)
  assign w_fold = (w_lfsr[5:0] >= C_DECK) ? (w_lfsr[5:0] - C_DECK) : w_lfsr[5:0];

  // Linear probe wraps from the last card back to card 0
  assign w_next_probe = (r_cand == C_LAST) ? 6'd0 : (r_cand + 6'd1);

  assign w_taken = r_mask[r_cand];

  // Suit/rank decode of the candidate by compare-subtract (no divider)
  always_comb begin
    w_suit = 2'd0;
    w_rem  = r_cand;
    if (r_cand >= C_R3) begin
      w_suit = 2'd3;
      w_rem  = r_cand - C_R3;
    end else if (r_cand >= C_R2) begin
      w_suit = 2'd2;
      w_rem  = r_cand - C_R2;
    end else if (r_cand >= C_R1) begin
      w_suit = 2'd1;
      w_rem  = r_cand - C_R1;
    end
    w_rank = 4'(w_rem + 6'd1);
  end

  // Previous control-path state for edge detection
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state_q <= CP_IDLE;
    end else begin
      r_state_q <= state_i;
    end
  end

  // Dealer FSM: request/shuffle handling, fold, probe and present
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_left  <= C_DECK;
      r_cand  <= 6'd0;
      r_card  <= 6'd0;
      r_suit  <= 2'd0;
      r_rank  <= 4'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Shuffle takes effect first so a same-cycle request sees a full deck
          if (shuffle_i) begin
            r_mask <= '0;
            r_left <= C_DECK;
          end
          if (w_req) begin
            if (shuffle_i || (r_left != 6'd0)) begin
              r_state <= ST_DRAW;
              r_busy  <= 1'b1;
            end else begin
`ifdef RNG_AUTO_SHUFFLE_EN
              r_mask  <= '0;
              r_left  <= C_DECK;
              r_state <= ST_DRAW;
              r_busy  <= 1'b1;
`else
              r_err   <= 1'b1;
`endif
            end
          end
        end

        ST_DRAW: begin
          r_cand  <= w_fold;
          r_state <= ST_CHECK;
        end

        ST_CHECK: begin
          // At least one card is free on entry, so this loop always ends
          if (!w_taken) begin
            r_mask[r_cand] <= 1'b1;
            if (r_left != 6'd0) begin
              r_left <= r_left - 6'd1;
            end
            r_card  <= r_cand;
            r_suit  <= w_suit;
            r_rank  <= w_rank;
            r_valid <= 1'b1;
            r_state <= ST_PRESENT;
          end else begin
            r_cand <= w_next_probe;
          end
        end

        ST_PRESENT: begin
          // Card fields are left holding the last dealt card after ack
          if (card_ack_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign card_o       = r_card;
  assign suit_o       = r_suit;
  assign rank_o       = r_rank;
  assign card_valid_o = r_valid;
  assign busy_o       = r_busy;
  assign cards_left_o = r_left;
  assign deck_empty_o = (r_left == 6'd0);
`ifdef RNG_AUTO_SHUFFLE_EN
  assign empty_err_o  = 1'b0;
`else
  assign empty_err_o  = r_err;
`endif

endmodule
`default_nettype wire
